// File: rtl/div_clk_ratio_detector.sv
// div_clk_ratio_detector
//   Receive-side companion to the selectable clock divider. It samples a
//   divided square wave in the clk domain and measures the number of clk
//   cycles between synchronized rising edges. It then decodes that period
//   back to the divide-select code that produced it:
//   00=1024, 01=2048, 10=4096, 11=8192 cycles.
//   After LOCK_N consecutive identical classifications it asserts valid.
//   It pulses err when lock is lost or when the input stalls.
//
// Ports
//   clk         system clock
//   rst         asynchronous, active-high reset
//   div_in      divided square wave under test (may be asynchronous)
//   code_out    decoded divide-select code; holds last locked value
//   valid       1 = locked; code_out / period_out trustworthy
//   period_out  most recent measured period in clk cycles
//   err         one-cycle pulse on loss of lock or input stall
//   state_dbg   current FSM state (0=IDLE, 1=MEASURE, 2=LOCKED)
module div_clk_ratio_detector #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 15,
  parameter int TOL         = 8,
  parameter int LOCK_N      = 2,
  parameter int TIMEOUT     = 16383
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_in,
  output logic [1:0]       code_out,
  output logic             valid,
  output logic [CNT_W-1:0] period_out,
  output logic             err,
  output logic [1:0]       state_dbg
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_MEASURE = 2'd1;
  localparam logic [1:0] S_LOCKED  = 2'd2;

  localparam int MW = (LOCK_N < 2) ? 1 : $clog2(LOCK_N + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  function automatic logic [CNT_W-1:0] nominal(input int k);
    nominal = CNT_W'(1 << (10 + k));
  endfunction

  logic [1:0]             state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_d;
  logic                   rise;
  logic [CNT_W-1:0]       cnt;
  logic                   cnt_at_to;
  logic [CNT_W-1:0]       period_meas;
  logic                   cls_hit;
  logic [1:0]             cls_code;
  logic [MW-1:0]          matches_q, matches_d, matches_upd;
  logic [1:0]             cand_q, cand_d, cand_upd;
  logic                   lock_hit;
  logic                   locked_ok;
  logic [1:0]             code_d;
  logic                   valid_d;
  logic [CNT_W-1:0]       period_d;
  logic                   err_d;

  // Synchronizer plus one delay flop; the added latency is identical for
  // every edge, so periods measured between rises are exact.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      sync_d <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], div_in};
      sync_d <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~sync_d;

  // Saturating period counter; restarts on every rise.
  assign cnt_at_to = (cnt == TIMEOUT_C);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (rise) begin
      cnt <= '0;
    end else if (!cnt_at_to) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // The rise cycle itself belongs to the period, hence the +1.
  assign period_meas = cnt + CNT_W'(1);

  // Window match |P - nominal| <= TOL, done as two unsigned compares.
  always_comb begin
    cls_hit  = 1'b0;
    cls_code = 2'd0;
    for (int k = 0; k < 4; k++) begin
      if (period_meas >= nominal(k) - CNT_W'(TOL) &&
          period_meas <= nominal(k) + CNT_W'(TOL)) begin
        cls_hit  = 1'b1;
        cls_code = 2'(k);
      end
    end
  end

  // Match-run bookkeeping for the measurement taken on this rise.
  always_comb begin
    if (cls_hit && matches_q != '0 && cls_code == cand_q) begin
      matches_upd = matches_q + MW'(1);
    end else if (cls_hit) begin
      matches_upd = MW'(1);
    end else begin
      matches_upd = '0;
    end
    cand_upd  = cls_hit ? cls_code : cand_q;
    lock_hit  = (matches_upd >= MW'(LOCK_N));
    locked_ok = cls_hit && (cls_code == code_out);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a rise always wins over a simultaneous timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (rise) state_d = S_MEASURE;
      end
      S_MEASURE: begin
        if (rise) begin
          if (lock_hit) state_d = S_LOCKED;
        end else if (cnt_at_to) begin
          state_d = S_IDLE;
        end
      end
      S_LOCKED: begin
        if (rise) begin
          if (!locked_ok) state_d = S_MEASURE;
        end else if (cnt_at_to) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    code_d    = code_out;
    valid_d   = valid;
    period_d  = period_out;
    err_d     = 1'b0;
    matches_d = matches_q;
    cand_d    = cand_q;
    case (state_q)
      S_IDLE: begin
        if (rise) matches_d = '0;
      end
      S_MEASURE: begin
        if (rise) begin
          period_d  = period_meas;
          matches_d = matches_upd;
          cand_d    = cand_upd;
          if (lock_hit) begin
            code_d  = cand_upd;
            valid_d = 1'b1;
          end
        end else if (cnt_at_to) begin
          err_d     = 1'b1;
          valid_d   = 1'b0;
          matches_d = '0;
        end
      end
      S_LOCKED: begin
        if (rise) begin
          period_d = period_meas;
          if (!locked_ok) begin
            // The mismatching period seeds the next match run.
            err_d     = 1'b1;
            valid_d   = 1'b0;
            matches_d = cls_hit ? MW'(1) : '0;
            cand_d    = cand_upd;
          end
        end else if (cnt_at_to) begin
          err_d     = 1'b1;
          valid_d   = 1'b0;
          matches_d = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code_out   <= 2'd0;
      valid      <= 1'b0;
      period_out <= '0;
      err        <= 1'b0;
      matches_q  <= '0;
      cand_q     <= 2'd0;
    end else begin
      code_out   <= code_d;
      valid      <= valid_d;
      period_out <= period_d;
      err        <= err_d;
      matches_q  <= matches_d;
      cand_q     <= cand_d;
    end
  end

  assign state_dbg = state_q;

endmodule
